// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states and the
// instruction-word constants used by the fetch logic and the IF/ID register.
package if_fetch_stage_pkg;

  localparam int          INST_W        = 32;
  localparam logic [31:0] HALT_WORD_DEF = 32'hEAFF_FFFF;
  localparam logic [31:0] NOP_WORD      = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush clears it, freeze holds it, otherwise it loads.
module if_id_reg
  import if_fetch_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic [31:0]       pc_in,
  input  logic [INST_W-1:0] inst_in,
  input  logic              valid_in,
  output logic [31:0]       pc_out,
  output logic [INST_W-1:0] inst_out,
  output logic              valid_out
);

  logic [31:0]       pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d;

  // Flush outranks freeze so a redirect always kills the held instruction.
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (flush) begin
      pc_d    = '0;
      inst_d  = NOP_WORD;
      valid_d = 1'b0;
    end else if (!freeze) begin
      pc_d    = pc_in;
      inst_d  = inst_in;
      valid_d = valid_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      inst_q  <= NOP_WORD;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign pc_out    = pc_q;
  assign inst_out  = inst_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, redirect mux, halt FSM and delivered
// instruction counter, feeding the IF/ID pipeline register.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [31:0]       branch_addr,
  output logic [31:0]       inst_addr,
  input  logic [INST_W-1:0] inst_in,
  output logic [INST_W-1:0] inst_id,
  output logic [31:0]       pc_id,
  output logic              valid_id,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [31:0]  pc_plus4;
  logic         normal_fetch;
  logic         halt_hit;

  assign pc_plus4     = pc_q + 32'd4;
  assign normal_fetch = !branch_taken && !freeze && (state_q == RUN);
  assign halt_hit     = normal_fetch && (inst_in == HALT_WORD);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    if (branch_taken) begin
      state_d = RUN;
      pc_d    = {branch_addr[31:2], 2'b00};
    end else if (normal_fetch) begin
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      // The halt word is still delivered, but the PC parks on its address.
      if (halt_hit) state_d = HALT;
      else          pc_d    = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .freeze    (freeze),
    .flush     (branch_taken),
    .pc_in     ((state_q == HALT) ? 32'h0 : pc_plus4),
    .inst_in   ((state_q == HALT) ? NOP_WORD : inst_in),
    .valid_in  (state_q == RUN),
    .pc_out    (pc_id),
    .inst_out  (inst_id),
    .valid_out (valid_id)
  );

  assign inst_addr   = pc_q;
  assign halted      = (state_q == HALT);
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model of the fetch rules.
module tb_if_fetch_stage;

  localparam logic [31:0] HALT_W   = 32'hEAFF_FFFF;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic [31:0] inst_addr;
  logic [31:0] inst_in;
  logic [31:0] inst_id;
  logic [31:0] pc_id;
  logic        valid_id;
  logic        halted;
  logic [15:0] fetch_count;

  logic        halt_en = 1'b0;
  logic [31:0] halt_addr = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(RESET_PC), .HALT_WORD(HALT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .inst_addr    (inst_addr),
    .inst_in      (inst_in),
    .inst_id      (inst_id),
    .pc_id        (pc_id),
    .valid_id     (valid_id),
    .halted       (halted),
    .fetch_count  (fetch_count)
  );

  // Instruction memory: address-hashed words that never equal the halt word.
  function automatic logic [31:0] hash_word(input logic [31:0] a);
    logic [31:0] w;
    w = (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    if (w == HALT_W) w = w ^ 32'h1;
    return w;
  endfunction

  assign inst_in = (halt_en && inst_addr == halt_addr) ? HALT_W : hash_word(inst_addr);

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (halt_en && a == halt_addr) ? HALT_W : hash_word(a);
  endfunction

  // Behavioural model
  logic        m_init = 1'b0;
  logic [31:0] m_pc, m_inst, m_pcid;
  logic        m_valid, m_halt;
  logic [15:0] m_cnt;

  task automatic model_step();
    logic [31:0] w;
    if (rst) begin
      m_init = 1'b1; m_pc = RESET_PC; m_inst = 0; m_pcid = 0;
      m_valid = 0; m_halt = 0; m_cnt = 0;
    end else if (!m_init) begin
      // outputs unknown before first reset
    end else if (branch_taken) begin
      m_pc = branch_addr & ~32'h3; m_inst = 0; m_pcid = 0; m_valid = 0; m_halt = 0;
    end else if (freeze) begin
      // everything holds
    end else if (m_halt) begin
      m_inst = 0; m_pcid = 0; m_valid = 0;
    end else begin
      w = mem_word(m_pc);
      m_inst = w; m_pcid = m_pc + 4; m_valid = 1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      if (w == HALT_W) m_halt = 1;
      else m_pc = m_pc + 4;
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      if (m_init) begin
        check32("m_inst_addr", inst_addr, m_pc);
        check32("m_inst_id", inst_id, m_inst);
        check32("m_pc_id", pc_id, m_pcid);
        check32("m_valid_id", {31'b0, valid_id}, {31'b0, m_valid});
        check32("m_halted", {31'b0, halted}, {31'b0, m_halt});
        check32("m_fetch_count", {16'b0, fetch_count}, {16'b0, m_cnt});
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    // Reset held for two edges
    tick(2);
    check32("rst_inst_addr", inst_addr, RESET_PC);
    check32("rst_valid", {31'b0, valid_id}, 32'h0);
    check32("rst_count", {16'b0, fetch_count}, 32'h0);
    check32("rst_halted", {31'b0, halted}, 32'h0);
    rst = 0;

    // First fetches W0, W1, then freeze for two edges at PC=8
    tick();
    check32("f1_inst", inst_id, hash_word(32'h0));
    check32("f1_pc", pc_id, 32'd4);
    tick();
    check32("f2_inst", inst_id, hash_word(32'h4));
    check32("f2_pc", pc_id, 32'd8);
    freeze = 1;
    tick(2);
    check32("frz_addr", inst_addr, 32'd8);
    check32("frz_pc", pc_id, 32'd8);
    check32("frz_inst", inst_id, hash_word(32'h4));
    check32("frz_valid", {31'b0, valid_id}, 32'h1);
    freeze = 0;
    tick();
    check32("f3_inst", inst_id, hash_word(32'h8));
    check32("f3_pc", pc_id, 32'd12);
    check32("f3_count", {16'b0, fetch_count}, 32'd3);

    // Branch while frozen
    freeze = 1; branch_taken = 1; branch_addr = 32'h0000_0073;
    tick();
    check32("br_addr", inst_addr, 32'h70);
    check32("br_valid", {31'b0, valid_id}, 32'h0);
    freeze = 0; branch_taken = 0;
    tick();
    check32("br_inst", inst_id, hash_word(32'h70));
    check32("br_pc", pc_id, 32'h74);

    // Halt word at 184
    halt_en = 1; halt_addr = 32'd184;
    branch_taken = 1; branch_addr = 32'd176;
    tick();
    branch_taken = 0;
    tick(3);
    check32("hlt_inst", inst_id, HALT_W);
    check32("hlt_pc", pc_id, 32'd188);
    check32("hlt_halted", {31'b0, halted}, 32'h1);
    check32("hlt_addr", inst_addr, 32'd184);
    tick(2);
    check32("hlt_valid", {31'b0, valid_id}, 32'h0);
    check32("hlt_addr2", inst_addr, 32'd184);
    branch_taken = 1; branch_addr = 32'h0;
    tick();
    branch_taken = 0;
    check32("unhlt_halted", {31'b0, halted}, 32'h0);
    check32("unhlt_addr", inst_addr, 32'h0);
    tick();
    check32("unhlt_inst", inst_id, hash_word(32'h0));

    // Run up to 46 delivered, then halt on the 47th
    for (int i = 0; i < 200 && m_cnt != 16'd46; i++) tick();
    check32("pre47_count", {16'b0, fetch_count}, 32'd46);
    halt_addr = inst_addr;
    tick();
    check32("c47_count", {16'b0, fetch_count}, 32'd47);
    check32("c47_halted", {31'b0, halted}, 32'h1);
    tick();
    rst = 1;
    tick();
    check32("rh_addr", inst_addr, RESET_PC);
    check32("rh_inst", inst_id, 32'h0);
    check32("rh_pc", pc_id, 32'h0);
    check32("rh_valid", {31'b0, valid_id}, 32'h0);
    check32("rh_halted", {31'b0, halted}, 32'h0);
    check32("rh_count", {16'b0, fetch_count}, 32'h0);
    rst = 0; halt_en = 0;

    // PC wrap
    branch_taken = 1; branch_addr = 32'hFFFF_FFF9;
    tick();
    branch_taken = 0;
    tick(2);
    check32("wrap_addr", inst_addr, 32'h0);
    check32("wrap_pc", pc_id, 32'h0);

    // Randomized traffic
    halt_en = 1;
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (i % 100 == 0) halt_addr = $urandom_range(0, 63) * 4;
      rst = (r == 0);
      branch_taken = (r >= 1 && r <= 6);
      branch_addr = (r == 6) ? $urandom : $urandom_range(0, 255);
      freeze = ($urandom_range(0, 3) == 0);
      tick();
    end
    rst = 0; branch_taken = 0; freeze = 0; halt_en = 0;

    // Counter saturation
    rst = 1;
    tick();
    rst = 0;
    tick(65535);
    check32("sat_count", {16'b0, fetch_count}, 32'h0000_FFFF);
    tick(5);
    check32("sat_hold", {16'b0, fetch_count}, 32'h0000_FFFF);
    check32("sat_valid", {31'b0, valid_id}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have parameter HALT_WORD, default 32'hEAFF_FFFF (B #-1), the instruction word that triggers halt.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port freeze, input, 1, hazard stall from ID: holds the PC and the IF/ID register.
REQ-006 SHALL have port branch_taken, input, 1, redirect request from EX; also flushes IF/ID.
REQ-007 SHALL have port branch_addr, input, 32, redirect target; bits [1:0] are ignored and forced to 0.
REQ-008 SHALL have port inst_addr, output, 32, current PC driven to the instruction memory; combinational from the PC register.
REQ-009 SHALL have port inst_in, input, 32, word returned combinationally by the instruction memory for inst_addr.
REQ-010 SHALL have port inst_id, output, 32, registered instruction for the ID stage.
REQ-011 SHALL have port pc_id, output, 32, registered fetch address + 4 for the ID stage.
REQ-012 SHALL have port valid_id, output, 1, high when inst_id holds a real instruction.
REQ-013 SHALL have port halted, output, 1, high while the FSM is in HALT.
REQ-014 SHALL have port fetch_count, output, 16, number of valid instructions delivered to ID; saturates at 16'hFFFF.

Function
REQ-015 SHALL apply per-edge priority: rst, then branch_taken, then freeze, then HALT hold, then normal fetch.
REQ-016 Normal fetch (RUN state): PC <= PC+4 (mod 2^32); inst_id <= inst_in; pc_id <= PC+4; valid_id <= 1.
REQ-017 Latency SHALL be one edge: the word at address A appears on inst_id one edge after inst_addr==A.
REQ-018 On branch_taken: PC <= {branch_addr[31:2],2'b00}; inst_id <= 0; pc_id <= 0; valid_id <= 0; FSM <= RUN. This applies in any state and regardless of freeze.
REQ-019 On freeze without branch_taken: PC, inst_id, pc_id, valid_id and fetch_count SHALL hold; FSM SHALL hold.
REQ-020 FSM SHALL have states RUN and HALT.
REQ-021 RUN->HALT SHALL occur when a normal fetch captures inst_in==HALT_WORD. That word is delivered with valid_id=1; the PC is not incremented.
REQ-022 In HALT: PC holds; each edge inst_id <= 0, pc_id <= 0, valid_id <= 0.
REQ-023 HALT->RUN SHALL occur only on branch_taken (REQ-018) or rst.
REQ-024 fetch_count SHALL increment on every edge that loads valid_id=1, and SHALL saturate at 16'hFFFF.
REQ-025 A HALT_WORD on inst_in SHALL be ignored on edges where branch_taken or freeze is asserted.
REQ-026 PC wrap from 32'hFFFF_FFFC SHALL go to 32'h0000_0000 with no error indication.

Reset
REQ-027 On rst: PC <= RESET_PC; inst_id <= 0; pc_id <= 0; valid_id <= 0; halted <= 0; fetch_count <= 0; FSM <= RUN.
REQ-028 While rst is high, inst_addr SHALL equal RESET_PC from the first edge onward. The first valid fetch SHALL be captured on the first edge with rst low.
REQ-029 rst asserted mid-operation (including while in HALT or frozen) SHALL override all other inputs on that edge.

Structure
REQ-030 The shared package SHALL hold: the FSM state enum {RUN, HALT}, the HALT_WORD default, the NOP word (32'h0), and the instruction width constant (32).
REQ-031 The IF/ID pipeline register SHALL be a sub-module if_id_reg with ports clk, rst, freeze, flush, pc_in, inst_in, valid_in, pc_out, inst_out, valid_out.
REQ-032 PC register, +4 adder, redirect mux, halt FSM and counter SHALL live in if_fetch_stage.

Verification
REQ-033 Bench SHALL cover reset release with memory returning words W0,W1,W2 at 0,4,8 -> inst_id=W0/W1/W2 on edges 1-3, pc_id=4/8/12, fetch_count=3.
REQ-034 Bench SHALL cover freeze high 2 cycles at PC=8 -> inst_addr stays 8, inst_id/pc_id/valid_id hold; fetch resumes at 8 afterwards.
REQ-035 Bench SHALL cover branch_taken with branch_addr=32'h0000_0073 while freeze=1 -> PC=32'h70, valid_id=0 next edge, then the word at 32'h70 on the following edge.
REQ-036 Bench SHALL cover HALT_WORD at address 184 -> delivered once with pc_id=188, halted=1, inst_addr stays 184, valid_id=0 thereafter; then branch_taken to 0 -> halted=0, fetch from 0.
REQ-037 Bench SHALL cover rst asserted while halted with fetch_count=47 -> all outputs at reset values after one edge, inst_addr=RESET_PC.
REQ-038 Bench SHALL cover fetch_count preloaded by 65535 valid fetches -> value remains 16'hFFFF on further fetches.
